prog_loader: RTL and testbench

//   Writer side of the instruction-memory interface that the fetch stage reads.

---
 rtl/prog_loader.sv | 125 ++++++++++++
 tb/tb_prog_loader.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Instruction-memory writer: unpacks a framed byte stream into little-endian
// 32-bit words, writes them from BASE_ADDR upward, then checks the XOR checksum.
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd128,
  parameter int          MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [15:0] words_done,
  output logic        done,
  output logic        error
);

  localparam logic [2:0] S_HDR0 = 3'd0;
  localparam logic [2:0] S_HDR1 = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CSUM = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam logic [15:0] MAXW = 16'(MAX_WORDS);

  logic [2:0]  state, state_nxt;
  logic [7:0]  nlo;
  logic [15:0] nwords;
  logic [15:0] wcnt;
  logic [1:0]  kidx;
  logic [23:0] wbuf;
  logic [7:0]  csum;
  logic        take;
  logic [15:0] hdr_n;

  assign take  = byte_valid & byte_ready;
  assign hdr_n = {byte_in, nlo};

  always_comb begin
    state_nxt = state;
    case (state)
      S_HDR0: if (take) state_nxt = S_HDR1;
      S_HDR1: if (take) begin
        if (hdr_n == 16'd0)    state_nxt = S_CSUM;
        else if (hdr_n > MAXW) state_nxt = S_ERR;
        else                   state_nxt = S_DATA;
      end
      S_DATA: if (take && kidx == 2'd3 && (wcnt + 16'd1) == nwords) state_nxt = S_CSUM;
      S_CSUM: if (take) state_nxt = (byte_in == csum) ? S_DONE : S_ERR;
      S_DONE, S_ERR: if (start) state_nxt = S_HDR0;
      default: state_nxt = S_HDR0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_HDR0;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= 32'd0;
      words_done <= 16'd0;
      done       <= 1'b0;
      error      <= 1'b0;
      csum       <= 8'd0;
      kidx       <= 2'd0;
      nlo        <= 8'd0;
      nwords     <= 16'd0;
      wcnt       <= 16'd0;
      wbuf       <= 24'd0;
    end else begin
      state      <= state_nxt;
      byte_ready <= (state_nxt != S_DONE) && (state_nxt != S_ERR);

      // A write strobe lives exactly one cycle; retire it and advance the address.
      if (mem_we) begin
        mem_we     <= 1'b0;
        mem_addr   <= mem_addr + 32'd4;
        words_done <= words_done + 16'd1;
      end

      case (state)
        S_HDR0: if (take) nlo <= byte_in;
        S_HDR1: if (take) begin
          nwords <= hdr_n;
          wcnt   <= 16'd0;
          kidx   <= 2'd0;
          if (hdr_n > MAXW) error <= 1'b1;
        end
        S_DATA: if (take) begin
          csum <= csum ^ byte_in;
          kidx <= kidx + 2'd1;
          case (kidx)
            2'd0: wbuf[7:0]   <= byte_in;
            2'd1: wbuf[15:8]  <= byte_in;
            2'd2: wbuf[23:16] <= byte_in;
            default: begin
              mem_we    <= 1'b1;
              mem_wdata <= {byte_in, wbuf};
              wcnt      <= wcnt + 16'd1;
            end
          endcase
        end
        S_CSUM: if (take) begin
          if (byte_in == csum) done  <= 1'b1;
          else                 error <= 1'b1;
        end
        S_DONE, S_ERR: if (start) begin
          done       <= 1'b0;
          error      <= 1'b0;
          words_done <= 16'd0;
          csum       <= 8'd0;
          kidx       <= 2'd0;
          mem_addr   <= BASE_ADDR;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: expected writes go into a scoreboard queue, a negedge
// monitor pops and compares each mem_we; status outputs are checked directly.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [15:0] words_done;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] sb_q[$];
  logic [7:0]  fb [12];
  logic [31:0] fw [3];

  prog_loader #(.BASE_ADDR(32'd128), .MAX_WORDS(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .words_done(words_done),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_write_pending", 32'(sb_q.size()), 32'd1);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        chk("wr_addr", mem_addr, e[63:32]);
        chk("wr_data", mem_wdata, e[31:0]);
      end
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    int tries;
    tries = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    if (!byte_ready) chk("byte_ready_timeout", {31'd0, byte_ready}, 32'd1);
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_frame(input bit bad_csum, input bit gaps);
    logic [7:0] cs;
    cs = 8'd0;
    for (int i = 0; i < 12; i++) cs = cs ^ fb[i];
    for (int i = 0; i < 3; i++) sb_q.push_back({32'd128 + 32'(4 * i), fw[i]});
    send(8'h03, gaps ? int'($urandom_range(0, 3)) : 0);
    send(8'h00, gaps ? int'($urandom_range(0, 3)) : 0);
    for (int i = 0; i < 12; i++) send(fb[i], gaps ? int'($urandom_range(0, 3)) : 0);
    send(bad_csum ? 8'h00 : cs, gaps ? int'($urandom_range(0, 3)) : 0);
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
    chk({tag, "_we"},    {31'd0, mem_we},     32'd0);
    chk({tag, "_addr"},  mem_addr,            32'd128);
    chk({tag, "_wdata"}, mem_wdata,           32'd0);
    chk({tag, "_words"}, {16'd0, words_done}, 32'd0);
    chk({tag, "_done"},  {31'd0, done},       32'd0);
    chk({tag, "_error"}, {31'd0, error},      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fb = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
           8'h33, 8'h01, 8'h00, 8'h00};
    fw = '{32'h0000_0013, 32'h0010_0093, 32'h0000_0133};

    // reset state
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst");
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_rst", {31'd0, byte_ready}, 32'd1);

    // good 3-word frame
    send_frame(1'b0, 1'b0);
    chk("t1_done",  {31'd0, done},       32'd1);
    chk("t1_error", {31'd0, error},      32'd0);
    chk("t1_words", {16'd0, words_done}, 32'd3);
    chk("t1_ready", {31'd0, byte_ready}, 32'd0);
    chk("t1_sb",    32'(sb_q.size()),    32'd0);

    // bad checksum: writes still happen
    pulse_start();
    chk("st_done_clr", {31'd0, done}, 32'd0);
    chk("st_addr",     mem_addr,      32'd128);
    send_frame(1'b1, 1'b0);
    chk("t2_done",  {31'd0, done},       32'd0);
    chk("t2_error", {31'd0, error},      32'd1);
    chk("t2_words", {16'd0, words_done}, 32'd3);
    chk("t2_sb",    32'(sb_q.size()),    32'd0);

    // N = 65 exceeds MAX_WORDS
    pulse_start();
    chk("st_err_clr", {31'd0, error},      32'd0);
    chk("st_words",   {16'd0, words_done}, 32'd0);
    send(8'h41, 0);
    send(8'h00, 0);
    @(negedge clk);
    chk("t3_error", {31'd0, error},      32'd1);
    chk("t3_done",  {31'd0, done},       32'd0);
    chk("t3_ready", {31'd0, byte_ready}, 32'd0);
    chk("t3_words", {16'd0, words_done}, 32'd0);

    // N = 0, checksum 00
    pulse_start();
    send(8'h00, 0);
    send(8'h00, 0);
    send(8'h00, 0);
    @(negedge clk);
    chk("t4_done",  {31'd0, done},       32'd1);
    chk("t4_words", {16'd0, words_done}, 32'd0);
    pulse_start();
    #1;
    chk("t4_done_clr", {31'd0, done},       32'd0);
    chk("t4_ready",    {31'd0, byte_ready}, 32'd1);

    // same frame with random valid gaps
    send_frame(1'b0, 1'b1);
    chk("t5_done",  {31'd0, done},       32'd1);
    chk("t5_words", {16'd0, words_done}, 32'd3);
    chk("t5_sb",    32'(sb_q.size()),    32'd0);

    // reset after the 6th data byte
    pulse_start();
    sb_q.push_back({32'd128, fw[0]});
    send(8'h03, 0);
    send(8'h00, 0);
    for (int i = 0; i < 6; i++) send(fb[i], 0);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    chk("midrst_sb", 32'(sb_q.size()), 32'd0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    send_frame(1'b0, 1'b0);
    chk("t6_done",  {31'd0, done},       32'd1);
    chk("t6_words", {16'd0, words_done}, 32'd3);
    chk("t6_sb",    32'(sb_q.size()),    32'd0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
